ex_branch_resolve: RTL and testbench
====================================

# ex_branch_resolve

Parametrised branch-resolution unit for the EX stage, generalising the dual-lane resolver to `LANES` issue lanes. It evaluates each lane's branch condition and target and selects the oldest mispredicting lane. It then kills younger lanes and issues a registered front-end redirect. Every resolved branch is buffered into an in-order update FIFO, which feeds the branch predictor over a valid/ready handshake, and the unit back-pressures EX when that FIFO cannot absorb a full issue group.

## Interface
Parameters:
- `LANES`, 2, number of issue lanes; lane 0 is oldest.
- `DEPTH`, 8, update-FIFO entries; power of two, `DEPTH >= 2*LANES`.
- `CNT_W`, 32, width of the mispredict performance counter.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `EX_valid` in LANES: lane holds a live instruction.
- `EX_stall` in 1: EX held by an external source; the group is not consumed.
- `EX_flush` in 1: an older-stage flush; the current group is discarded.
- `EX_pc` in LANES*32: PC per lane.
- `EX_rdata1`, `EX_rdata2` in LANES*32 each: forwarded source operands.
- `EX_imm` in LANES*32: sign-extended, pre-shifted offset.
- `EX_br_type` in LANES*4: branch type; 0 means not a branch.
- `EX_br_pd` in LANES: predicted taken.
- `EX_pc_pd` in LANES*32: predicted next PC.
- `EX_kill` out LANES: combinational; lanes younger than the first mispredict.
- `EX_busy` out 1: registered-state derived; EX must stall.
- `br_redirect` out 1: registered one-cycle pulse.
- `br_redirect_pc` out 32: corrected fetch PC, valid while `br_redirect` is high.
- `upd_valid` out 1, `upd_ready` in 1: predictor update handshake.
- `upd_pc` out 32, `upd_target` out 32, `upd_taken` out 1, `upd_type` out 4: fields of the update record.
- `mispred_cnt` out CNT_W: saturating count of redirects.

## Operation
- **Per-lane evaluation:**
  - `taken`: BEQ/BNE/BLT/BGE compare signed; BLTU/BGEU compare unsigned; B, BL and JIRL are always taken.
  - `target`:
    - JIRL: `rdata1+imm`.
    - Other branches: `pc+imm`.
  - `next = taken ? target : pc+4`. All arithmetic is mod 2^32.
  - Non-branch lane: `next = pc+4`.
- **Mispredict:** lane i mispredicts when it is valid and `EX_pc_pd[i] != next[i]`. This applies to non-branch lanes as well, so a bogus predicted jump is caught.
- **Fire condition:** `fire = |EX_valid & !EX_stall & !EX_busy & !EX_flush`.
- **First mispredict:** `m` is the lowest-index mispredicting valid lane.
- **Kill mask:** `EX_kill[j]=1` for all j>m. The mask is all-zero when there is no mispredict or `EX_flush` is high. `EX_kill` is computed regardless of `fire`.
- **Redirect register:** on `fire` with a mispredict, the next cycle sets `br_redirect=1` and `br_redirect_pc=next[m]`. In all other cycles `br_redirect=0`.
- **Counter:** `mispred_cnt` increments on each redirect and saturates at all-ones.
- **FIFO push:** on `fire`, push one record per valid branch lane with index ≤ m (or all valid branch lanes if there is no mispredict), in lane order. Record contents: `{pc, target, taken, br_type}`. Up to LANES pushes happen per cycle.
- **FIFO pop:** when `upd_valid & upd_ready`. The head record drives the `upd_*` outputs, and `upd_valid = (count != 0)`.
- **Busy:** `EX_busy = (DEPTH - count) < LANES`, computed from the registered count only. There is no combinational path from `upd_ready`.

## Timing
- Redirect latency is one cycle from the firing edge. Kill has zero latency.
- Push and pop may occur in the same cycle: `count_next = count + pushes - pop`. The FIFO never overflows by construction of `EX_busy`.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH. Full and empty are distinguished by `count` (width clog2(DEPTH)+1).
- **Back-pressure:** `upd_valid` stays high and the head record stays stable until accepted. `upd_ready` low for any duration loses nothing.
- **`EX_flush` and `EX_stall`:**
  - A cycle with `EX_flush` high produces no push, no redirect and no counter change.
  - `EX_flush` does not cancel a redirect already registered, and leaves FIFO contents intact.
  - A cycle with `EX_stall` high has no side effects.
- **Reset:** on a `rst` edge the following are forced to 0:
  - FIFO pointers and count,
  - `br_redirect`, `br_redirect_pc`,
  - `upd_valid`,
  - `mispred_cnt`.
  - `EX_busy` is 0 once count is 0.
  - Reset asserted mid-operation discards all FIFO entries and any pending redirect.

## Structure
- Package `br_pkg`: the `br_type_e` 4-bit enum and the `br_upd_t` struct `{pc, target, taken, type}`. Enum encodings:
  - NONE=0, JIRL=1, B=2, BL=3, BEQ=4, BNE=5, BLT=6, BGE=7, BLTU=8, BGEU=9.
- Sub-module `br_lane_eval` (combinational): inputs pc, rdata1, rdata2, imm, type; outputs taken, target, next. Instantiated LANES times via generate.
- The FIFO is implemented inline as a multi-push, single-pop circular buffer.

## Test plan
- **Single lane, correct prediction.** LANES=2. Lane0 BEQ, pc=0x1000, rdata1=rdata2=5, imm=0x40, pd=1, pc_pd=0x1040.
  - Expect no kill and no redirect.
  - One update `{0x1000, 0x1040, 1, BEQ}` appears one cycle later.
- **Lane 0 mispredict.** Lane0 BNE with equal operands, pc=0x2000, pc_pd=0x2100; lane1 is valid.
  - Expect `EX_kill=2'b10`.
  - Next cycle `br_redirect=1`, `br_redirect_pc=0x2004`, `mispred_cnt=1`.
  - Exactly one update is pushed (lane 1 is killed).
- **JIRL target.** rdata1=0x3000, imm=-8, pc_pd=0.
  - Expect `br_redirect_pc=0x2FF8`.
  - Update record has `taken=1`.
- **Back-pressure.** Hold `upd_ready=0` while issuing 2-branch groups with DEPTH=8.
  - `EX_busy` rises when count=7.
  - No push occurs while busy.
  - Releasing `upd_ready` drains all 7 records in order.
- **Flush, stall and reset.**
  - A mispredicting group with `EX_flush=1`: no redirect, no push.
  - The same group with `EX_stall=1`: no side effects.
  - `rst` pulsed with 3 entries queued: `upd_valid=0` and `mispred_cnt=0` on the next cycle.

Source files
------------

// File: rtl/br_pkg.sv
// Shared branch-type encoding and predictor update record for the EX branch resolver.
package br_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    JIRL = 4'd1,
    B    = 4'd2,
    BL   = 4'd3,
    BEQ  = 4'd4,
    BNE  = 4'd5,
    BLT  = 4'd6,
    BGE  = 4'd7,
    BLTU = 4'd8,
    BGEU = 4'd9
  } br_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    br_type_e    br_type;
  } br_upd_t;

  // Codes 10..15 are unassigned and handled like a plain fall-through instruction.
  function automatic logic is_branch(input logic [3:0] t);
    return (t != 4'd0) && (t <= 4'd9);
  endfunction

endpackage

// File: rtl/ex_branch_resolve_if.sv
// Predictor update channel: one resolved-branch record per valid/ready transfer.
interface ex_branch_resolve_if;

  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [3:0]  upd_type;

  modport master (
    output upd_valid, upd_pc, upd_target, upd_taken, upd_type,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_type,
    output upd_ready
  );

endinterface

// File: rtl/br_lane_eval.sv
// Combinational evaluation of one lane: branch condition, target and actual next PC.
module br_lane_eval
  import br_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] imm,
  input  br_type_e    br_type,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] next_pc
);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      JIRL, B, BL: taken = 1'b1;
      BEQ:         taken = (rdata1 == rdata2);
      BNE:         taken = (rdata1 != rdata2);
      BLT:         taken = ($signed(rdata1) <  $signed(rdata2));
      BGE:         taken = ($signed(rdata1) >= $signed(rdata2));
      BLTU:        taken = (rdata1 <  rdata2);
      BGEU:        taken = (rdata1 >= rdata2);
      default:     taken = 1'b0;
    endcase
    target  = (br_type == JIRL) ? rdata1 + imm : pc + imm;
    next_pc = taken ? target : pc + 32'd4;
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolver: oldest-mispredict selection, younger-lane kill, registered
// redirect, and an in-order multi-push update FIFO feeding the branch predictor.
module ex_branch_resolve
  import br_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LANES-1:0]     EX_valid,
  input  logic                 EX_stall,
  input  logic                 EX_flush,
  input  logic [LANES*32-1:0]  EX_pc,
  input  logic [LANES*32-1:0]  EX_rdata1,
  input  logic [LANES*32-1:0]  EX_rdata2,
  input  logic [LANES*32-1:0]  EX_imm,
  input  logic [LANES*4-1:0]   EX_br_type,
  input  logic [LANES-1:0]     EX_br_pd,
  input  logic [LANES*32-1:0]  EX_pc_pd,
  output logic [LANES-1:0]     EX_kill,
  output logic                 EX_busy,
  output logic                 br_redirect,
  output logic [31:0]          br_redirect_pc,
  output logic [CNT_W-1:0]     mispred_cnt,
  ex_branch_resolve_if.master  upd
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t BUSY_TH = cnt_t'(DEPTH - LANES);

  logic [LANES-1:0] lane_taken;
  logic [31:0]      lane_target [LANES];
  logic [31:0]      lane_next   [LANES];

  logic [LANES-1:0] kill_raw;
  logic [LANES-1:0] push_en;
  logic             mis_any;
  logic [31:0]      mis_next;
  logic             fire;
  logic             pop;
  cnt_t             n_push;

  br_upd_t          mem_q [DEPTH];
  br_upd_t          mem_d [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  br_upd_t          head;

  // The predicted-direction bit is implied by EX_pc_pd, so only the PC comparison matters.
  logic unused_br_pd;
  assign unused_br_pd = ^EX_br_pd;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    br_lane_eval u_eval (
      .pc      (EX_pc[i*32 +: 32]),
      .rdata1  (EX_rdata1[i*32 +: 32]),
      .rdata2  (EX_rdata2[i*32 +: 32]),
      .imm     (EX_imm[i*32 +: 32]),
      .br_type (br_type_e'(EX_br_type[i*4 +: 4])),
      .taken   (lane_taken[i]),
      .target  (lane_target[i]),
      .next_pc (lane_next[i])
    );
  end

  // Walk lanes oldest-first; everything after the first mispredict is dead.
  always_comb begin
    mis_any  = 1'b0;
    mis_next = '0;
    kill_raw = '0;
    push_en  = '0;
    for (int i = 0; i < LANES; i++) begin
      kill_raw[i] = mis_any;
      push_en[i]  = EX_valid[i] && is_branch(EX_br_type[i*4 +: 4]) && !mis_any;
      if (!mis_any && EX_valid[i] && (EX_pc_pd[i*32 +: 32] != lane_next[i])) begin
        mis_any  = 1'b1;
        mis_next = lane_next[i];
      end
    end
  end

  assign EX_kill = EX_flush ? '0 : kill_raw;
  assign EX_busy = (count_q > BUSY_TH);
  assign fire    = (|EX_valid) && !EX_stall && !EX_busy && !EX_flush;

  assign head           = mem_q[rd_ptr_q];
  assign upd.upd_valid  = (count_q != '0);
  assign upd.upd_pc     = head.pc;
  assign upd.upd_target = head.target;
  assign upd.upd_taken  = head.taken;
  assign upd.upd_type   = head.br_type;
  assign pop            = upd.upd_valid && upd.upd_ready;

  // Surviving branch lanes are packed into consecutive slots in lane order.
  always_comb begin
    mem_d  = mem_q;
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      if (fire && push_en[i]) begin
        mem_d[wr_ptr_q + ptr_t'(n_push)] = '{
          pc:      EX_pc[i*32 +: 32],
          target:  lane_target[i],
          taken:   lane_taken[i],
          br_type: br_type_e'(EX_br_type[i*4 +: 4])
        };
        n_push = n_push + cnt_t'(1);
      end
    end
    wr_ptr_d = wr_ptr_q + ptr_t'(n_push);
    rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    count_d  = count_q + n_push - (pop ? cnt_t'(1) : cnt_t'(0));
  end

  always_comb begin
    redirect_d    = fire && mis_any;
    redirect_pc_d = (fire && mis_any) ? mis_next : redirect_pc_q;
    cnt_d         = (fire && mis_any && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign br_redirect    = redirect_q;
  assign br_redirect_pc = redirect_pc_q;
  assign mispred_cnt    = cnt_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed bench for ex_branch_resolve with a queue-based reference model checked every cycle.
module tb_ex_branch_resolve;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = 2;

  localparam logic [3:0] T_NONE = 4'd0, T_JIRL = 4'd1, T_B = 4'd2, T_BEQ = 4'd4,
                         T_BNE = 4'd5, T_BLT = 4'd6, T_BLTU = 4'd8, T_BGEU = 4'd9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [LANES-1:0]    ex_valid, ex_br_pd, ex_kill;
  logic                ex_stall, ex_flush, ex_busy, br_redirect;
  logic [LANES*32-1:0] ex_pc, ex_r1, ex_r2, ex_imm, ex_pc_pd;
  logic [LANES*4-1:0]  ex_type;
  logic [31:0]         br_redirect_pc;
  logic [CNT_W-1:0]    mispred_cnt;

  ex_branch_resolve_if upd_if ();

  ex_branch_resolve #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .EX_valid       (ex_valid),
    .EX_stall       (ex_stall),
    .EX_flush       (ex_flush),
    .EX_pc          (ex_pc),
    .EX_rdata1      (ex_r1),
    .EX_rdata2      (ex_r2),
    .EX_imm         (ex_imm),
    .EX_br_type     (ex_type),
    .EX_br_pd       (ex_br_pd),
    .EX_pc_pd       (ex_pc_pd),
    .EX_kill        (ex_kill),
    .EX_busy        (ex_busy),
    .br_redirect    (br_redirect),
    .br_redirect_pc (br_redirect_pc),
    .mispred_cnt    (mispred_cnt),
    .upd            (upd_if.master)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tg;
    logic        tk;
    logic [3:0]  ty;
  } rec_t;

  rec_t             mq[$];
  logic             m_redir = 1'b0;
  logic [31:0]      m_rpc = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  int               n_checks = 0;
  int               n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lane_eval(input logic [31:0] pc, r1, r2, imm, input logic [3:0] t,
                                    output logic isb, output logic tk,
                                    output logic [31:0] tg, output logic [31:0] nx);
    isb = (t >= 4'd1) && (t <= 4'd9);
    tg  = (t == T_JIRL) ? r1 + imm : pc + imm;
    case (t)
      4'd1, 4'd2, 4'd3: tk = 1'b1;
      4'd4: tk = (r1 == r2);
      4'd5: tk = (r1 != r2);
      4'd6: tk = ($signed(r1) <  $signed(r2));
      4'd7: tk = ($signed(r1) >= $signed(r2));
      4'd8: tk = (r1 <  r2);
      4'd9: tk = (r1 >= r2);
      default: tk = 1'b0;
    endcase
    nx = tk ? tg : pc + 32'd4;
  endfunction

  function automatic int first_mis(output logic [31:0] nx_m);
    logic isb, tk;
    logic [31:0] tg, nx;
    nx_m = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_eval(ex_pc[i*32 +: 32], ex_r1[i*32 +: 32], ex_r2[i*32 +: 32], ex_imm[i*32 +: 32],
                ex_type[i*4 +: 4], isb, tk, tg, nx);
      if (ex_valid[i] && (ex_pc_pd[i*32 +: 32] != nx)) begin
        nx_m = nx;
        return i;
      end
    end
    return -1;
  endfunction

  // Reference model: advances on the same edge the DUT samples.
  always @(posedge clk) begin
    int m;
    logic [31:0] nx_m, tg, nx;
    logic fire, pop, isb, tk;
    if (rst) begin
      mq.delete();
      m_redir = 1'b0;
      m_rpc   = '0;
      m_cnt   = '0;
    end else begin
      m    = first_mis(nx_m);
      fire = (|ex_valid) && !ex_stall && !ex_flush && ((DEPTH - mq.size()) >= LANES);
      pop  = (mq.size() > 0) && upd_if.upd_ready;
      m_redir = fire && (m >= 0);
      if (m_redir) begin
        m_rpc = nx_m;
        if (m_cnt != '1) m_cnt++;
      end
      if (pop) void'(mq.pop_front());
      if (fire) begin
        for (int i = 0; i < LANES; i++) begin
          lane_eval(ex_pc[i*32 +: 32], ex_r1[i*32 +: 32], ex_r2[i*32 +: 32], ex_imm[i*32 +: 32],
                    ex_type[i*4 +: 4], isb, tk, tg, nx);
          if (ex_valid[i] && isb && (m < 0 || i <= m))
            mq.push_back('{pc: ex_pc[i*32 +: 32], tg: tg, tk: tk, ty: ex_type[i*4 +: 4]});
        end
      end
    end
  end

  always @(negedge clk) begin
    int m;
    logic [31:0] nx_m;
    logic [LANES-1:0] ek;
    m  = first_mis(nx_m);
    ek = '0;
    if (m >= 0 && !ex_flush)
      for (int j = 0; j < LANES; j++) if (j > m) ek[j] = 1'b1;
    chk("kill", ex_kill, ek);
    chk("busy", ex_busy, (DEPTH - mq.size()) < LANES);
    chk("redirect", br_redirect, m_redir);
    if (m_redir) chk("redirect_pc", br_redirect_pc, m_rpc);
    chk("mispred_cnt", mispred_cnt, m_cnt);
    chk("upd_valid", upd_if.upd_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("upd_pc", upd_if.upd_pc, mq[0].pc);
      chk("upd_target", upd_if.upd_target, mq[0].tg);
      chk("upd_taken", upd_if.upd_taken, mq[0].tk);
      chk("upd_type", upd_if.upd_type, mq[0].ty);
    end
  end

  task automatic clr();
    ex_valid = '0; ex_stall = 1'b0; ex_flush = 1'b0; ex_br_pd = '0;
    ex_pc = '0; ex_r1 = '0; ex_r2 = '0; ex_imm = '0; ex_type = '0; ex_pc_pd = '0;
  endtask

  task automatic lane(input int i, input logic [31:0] pc, r1, r2, imm, input logic [3:0] t,
                      input logic pd, input logic [31:0] pcpd);
    ex_valid[i]          = 1'b1;
    ex_pc[i*32 +: 32]    = pc;
    ex_r1[i*32 +: 32]    = r1;
    ex_r2[i*32 +: 32]    = r2;
    ex_imm[i*32 +: 32]   = imm;
    ex_type[i*4 +: 4]    = t;
    ex_br_pd[i]          = pd;
    ex_pc_pd[i*32 +: 32] = pcpd;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [31:0] drain_pc [7];

  initial begin
    clr();
    rst = 1'b1;
    upd_if.upd_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_upd_valid", upd_if.upd_valid, 0);
    chk("rst_cnt", mispred_cnt, 0);
    chk("rst_busy", ex_busy, 0);
    chk("rst_redirect", br_redirect, 0);

    // correctly predicted BEQ
    lane(0, 32'h1000, 32'd5, 32'd5, 32'h40, T_BEQ, 1'b1, 32'h1040);
    #1 chk("t1_kill", ex_kill, 2'b00);
    cyc();
    chk("t1_redirect", br_redirect, 0);
    chk("t1_upd_valid", upd_if.upd_valid, 1);
    chk("t1_upd_pc", upd_if.upd_pc, 32'h1000);
    chk("t1_upd_target", upd_if.upd_target, 32'h1040);
    chk("t1_upd_taken", upd_if.upd_taken, 1);
    chk("t1_upd_type", upd_if.upd_type, 4);
    clr(); cyc();
    chk("t1_drained", upd_if.upd_valid, 0);

    // lane 0 mispredict kills lane 1
    upd_if.upd_ready = 1'b0;
    lane(0, 32'h2000, 32'd7, 32'd7, 32'h100, T_BNE, 1'b1, 32'h2100);
    lane(1, 32'h2004, 32'd1, 32'd1, 32'h8, T_BEQ, 1'b1, 32'h200C);
    #1 chk("t2_kill", ex_kill, 2'b10);
    cyc();
    chk("t2_redirect", br_redirect, 1);
    chk("t2_redirect_pc", br_redirect_pc, 32'h2004);
    chk("t2_cnt", mispred_cnt, 1);
    chk("t2_upd_pc", upd_if.upd_pc, 32'h2000);
    chk("t2_upd_taken", upd_if.upd_taken, 0);
    clr();
    upd_if.upd_ready = 1'b1;
    cyc();
    chk("t2_redirect_pulse", br_redirect, 0);
    chk("t2_single_push", upd_if.upd_valid, 0);

    // JIRL target from rdata1
    lane(0, 32'h2500, 32'h3000, 32'd0, 32'hFFFF_FFF8, T_JIRL, 1'b1, 32'h0);
    cyc();
    chk("t3_redirect_pc", br_redirect_pc, 32'h2FF8);
    chk("t3_upd_taken", upd_if.upd_taken, 1);
    chk("t3_upd_target", upd_if.upd_target, 32'h2FF8);
    chk("t3_cnt", mispred_cnt, 2);
    clr(); cyc();

    // back-pressure: fill to 7 with the update port stalled
    upd_if.upd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clr();
      lane(0, 32'h4000 + 32'(k*16), 32'hFFFF_FFFF, 32'd1, 32'h20, T_BLT, 1'b1,
           32'h4020 + 32'(k*16));
      lane(1, 32'h4004 + 32'(k*16), 32'hFFFF_FFFF, 32'd1, 32'h20, T_BLTU, 1'b0,
           32'h4008 + 32'(k*16));
      cyc();
      chk("bp_busy_low", ex_busy, 0);
    end
    clr();
    lane(0, 32'h4030, 32'd1, 32'd2, 32'h20, T_BGEU, 1'b0, 32'h4034);
    lane(1, 32'h4034, 32'd0, 32'd0, 32'd0, T_NONE, 1'b0, 32'h4038);
    cyc();
    chk("bp_busy_at7", ex_busy, 1);
    clr();
    lane(0, 32'h5000, 32'd0, 32'd0, 32'h80, T_B, 1'b0, 32'h5004);
    lane(1, 32'h5004, 32'd3, 32'd3, 32'h10, T_BEQ, 1'b1, 32'h5014);
    #1 chk("bp_kill_while_busy", ex_kill, 2'b10);
    cyc();
    chk("bp_no_redirect", br_redirect, 0);
    chk("bp_still_busy", ex_busy, 1);
    chk("bp_cnt_hold", mispred_cnt, 2);
    clr(); cyc();
    chk("bp_head_stable", upd_if.upd_pc, 32'h4000);
    drain_pc = '{32'h4000, 32'h4004, 32'h4010, 32'h4014, 32'h4020, 32'h4024, 32'h4030};
    upd_if.upd_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("drain_pc", upd_if.upd_pc, drain_pc[i]);
      cyc();
    end
    chk("drain_empty", upd_if.upd_valid, 0);

    // flush then stall on a mispredicting group
    clr();
    ex_flush = 1'b1;
    lane(0, 32'h6000, 32'd2, 32'd2, 32'h40, T_BNE, 1'b1, 32'h6040);
    lane(1, 32'h6004, 32'd2, 32'd2, 32'h40, T_BEQ, 1'b1, 32'h6044);
    #1 chk("flush_kill", ex_kill, 2'b00);
    cyc();
    chk("flush_redirect", br_redirect, 0);
    chk("flush_push", upd_if.upd_valid, 0);
    chk("flush_cnt", mispred_cnt, 2);
    ex_flush = 1'b0;
    ex_stall = 1'b1;
    #1 chk("stall_kill", ex_kill, 2'b10);
    cyc();
    chk("stall_redirect", br_redirect, 0);
    chk("stall_push", upd_if.upd_valid, 0);
    chk("stall_cnt", mispred_cnt, 2);

    // bogus predicted jumps on non-branch lanes; counter saturates at 3
    clr();
    lane(0, 32'h7000, 32'd0, 32'd0, 32'd0, T_NONE, 1'b1, 32'h8000);
    cyc();
    chk("nb_redirect", br_redirect, 1);
    chk("nb_redirect_pc", br_redirect_pc, 32'h7004);
    chk("nb_cnt", mispred_cnt, 3);
    chk("nb_no_push", upd_if.upd_valid, 0);
    clr();
    lane(0, 32'h7100, 32'd0, 32'd0, 32'd0, T_NONE, 1'b0, 32'h7104);
    lane(1, 32'h7104, 32'd0, 32'd0, 32'd0, T_NONE, 1'b1, 32'h9000);
    cyc();
    chk("sat_redirect_pc", br_redirect_pc, 32'h7108);
    chk("sat_cnt", mispred_cnt, 3);

    // reset with three records queued and a redirect pending
    upd_if.upd_ready = 1'b0;
    clr();
    lane(0, 32'hA000, 32'd4, 32'd4, 32'h10, T_BEQ, 1'b1, 32'hA010);
    cyc();
    clr();
    lane(0, 32'hA100, 32'd1, 32'd2, 32'h20, T_BNE, 1'b1, 32'hA120);
    lane(1, 32'hA104, 32'd1, 32'd2, 32'h20, T_BEQ, 1'b1, 32'hA124);
    cyc();
    chk("pre_rst_redirect_pc", br_redirect_pc, 32'hA108);
    chk("pre_rst_head", upd_if.upd_pc, 32'hA000);
    clr();
    rst = 1'b1;
    cyc();
    chk("rst_mid_upd_valid", upd_if.upd_valid, 0);
    chk("rst_mid_cnt", mispred_cnt, 0);
    chk("rst_mid_redirect", br_redirect, 0);
    chk("rst_mid_busy", ex_busy, 0);
    rst = 1'b0;
    upd_if.upd_ready = 1'b1;
    cyc();
    chk("post_rst_empty", upd_if.upd_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
